// File: rtl/puf_pkg.sv
// Shared types and constants for the arbiter-PUF challenge driver.
// Holds the FSM state encoding and the 16-bit LFSR definition.
package puf_pkg;

  localparam int CHAL_W = 16;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [CHAL_W-1:0] LFSR_TAP_MASK = 16'hB400;
  localparam logic [CHAL_W-1:0] LFSR_ZERO_SUB = 16'h0001;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    WAIT,
    SAMPLE,
    EMIT
  } state_e;

  function automatic logic [CHAL_W-1:0] lfsr_next(input logic [CHAL_W-1:0] s);
    return {s[CHAL_W-2:0], ^(s & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/puf_lfsr16.sv
// 16-bit Fibonacci LFSR producing the challenge sequence.
// A zero seed would lock the register, so it is replaced on load.
module puf_lfsr16
  import puf_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [CHAL_W-1:0] seed_i,
  input  logic              step_i,
  output logic [CHAL_W-1:0] state_o
);

  logic [CHAL_W-1:0] state_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= '0;
    end else if (load_i) begin
      state_q <= (seed_i == '0) ? LFSR_ZERO_SUB : seed_i;
    end else if (step_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/puf_challenge_driver.sv
// Applies LFSR challenges to an arbiter PUF, pulses it, samples the
// synchronized response and packs the bits into valid/ready words.
module puf_challenge_driver #(
  parameter int CHAL_W     = 16,
  parameter int SETTLE_CYC = 8,
  parameter int PULSE_W    = 2,
  parameter int SAMPLE_CYC = 4,
  parameter int RESP_W     = 32
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic [15:0]       seed_i,
  input  logic [15:0]       count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CHAL_W-1:0] ichallenge_o,
  output logic              ipulse_o,
  input  logic              oresponse_i,
  output logic [RESP_W-1:0] resp_data_o,
  output logic              resp_valid_o,
  input  logic              resp_ready_i
);
  import puf_pkg::*;

  localparam int BIDX_W  = (RESP_W > 1) ? $clog2(RESP_W) : 1;
  localparam int CNT_MAX = (SETTLE_CYC > PULSE_W)
                           ? ((SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC)
                           : ((PULSE_W > SAMPLE_CYC) ? PULSE_W : SAMPLE_CYC);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LD = CNT_W'(SAMPLE_CYC - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(RESP_W - 1);

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [15:0]         remaining_q;
  logic [BIDX_W-1:0]   bit_idx_q;
  logic [RESP_W-1:0]   shreg_q;
  logic [RESP_W-1:0]   word_d;
  logic                sync1_q;
  logic                sync2_q;
  logic                ipulse_q;
  logic                busy_q;
  logic                done_q;
  logic                resp_valid_q;
  logic [RESP_W-1:0]   resp_data_q;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                sample_last;
  logic [puf_pkg::CHAL_W-1:0] lfsr_state;

  // Two-flop synchronizer; only sync2_q is ever consumed.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= oresponse_i;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    word_d            = shreg_q;
    word_d[bit_idx_q] = sync2_q;
  end

  assign sample_last = (bit_idx_q == BIDX_LAST) || (remaining_q == 16'd1);

  always_comb begin
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (state_q)
      IDLE:    lfsr_load = start_i && (count_i != 16'd0);
      SAMPLE:  lfsr_step = !sample_last;
      EMIT:    lfsr_step = resp_ready_i && (remaining_q != 16'd0);
      default: ;
    endcase
  end

  puf_lfsr16 u_lfsr (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .load_i  (lfsr_load),
    .seed_i  (seed_i),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  // NOTE: non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      remaining_q  <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      ipulse_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (count_i == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q     <= SETUP;
              busy_q      <= 1'b1;
              remaining_q <= count_i;
              bit_idx_q   <= '0;
              shreg_q     <= '0;
              cnt_q       <= SETTLE_LD;
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            state_q  <= PULSE;
            ipulse_q <= 1'b1;
            cnt_q    <= PULSE_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt_q == '0) begin
            state_q  <= WAIT;
            ipulse_q <= 1'b0;
            cnt_q    <= SAMPLE_LD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        SAMPLE: begin
          shreg_q     <= word_d;
          remaining_q <= remaining_q - 16'd1;
          if (sample_last) begin
            state_q      <= EMIT;
            resp_valid_q <= 1'b1;
            resp_data_q  <= word_d;
          end else begin
            state_q   <= SETUP;
            bit_idx_q <= bit_idx_q + BIDX_W'(1);
            cnt_q     <= SETTLE_LD;
          end
        end
        EMIT: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            if (remaining_q != 16'd0) begin
              state_q <= SETUP;
              cnt_q   <= SETTLE_LD;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign ipulse_o     = ipulse_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign ichallenge_o = CHAL_W'(lfsr_state);

endmodule

// File: tb/tb_puf_challenge_driver.sv
// Scoreboard bench for puf_challenge_driver: expected words are queued as
// response bits are driven and popped when the DUT hands a word out.
module tb_puf_challenge_driver;

  localparam int SETTLE = 8;
  localparam int PW     = 2;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [15:0] seed_i = '0;
  logic [15:0] count_i = '0;
  logic        busy_o;
  logic        done_o;
  logic [15:0] ichallenge_o;
  logic        ipulse_o;
  logic        oresponse_i = 1'b0;
  logic [31:0] resp_data_o;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  puf_challenge_driver dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (wb_rst_i),
    .start_i      (start_i),
    .seed_i       (seed_i),
    .count_i      (count_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .ichallenge_o (ichallenge_o),
    .ipulse_o     (ipulse_o),
    .oresponse_i  (oresponse_i),
    .resp_data_o  (resp_data_o),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] model_next(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Monitor: pulse shape, challenge stability, handshake scoreboard.
  logic        prev_pulse = 1'b0;
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [15:0] prev_chal = '0;
  logic [31:0] prev_data = '0;
  int          pulse_len = 0;
  int          chal_cyc = 0;

  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (!wb_rst_i) begin
      if (ipulse_o && !prev_pulse) begin
        pulse_len = 1;
        pulse_cnt++;
        checks++;
        if (cyc - chal_cyc < SETTLE) begin
          failures++;
          $display("FAIL settle: challenge stable %0d cycles before pulse, need %0d", cyc - chal_cyc, SETTLE);
        end
      end else if (ipulse_o) begin
        pulse_len++;
        checks++;
        if (ichallenge_o !== prev_chal) begin
          failures++;
          $display("FAIL chal_during_pulse: got %h, held %h", ichallenge_o, prev_chal);
        end
      end else if (prev_pulse) begin
        checks++;
        if (pulse_len != PW) begin
          failures++;
          $display("FAIL pulse_width: got %0d, expected %0d", pulse_len, PW);
        end
      end
      if (prev_valid && !prev_ready) begin
        checks++;
        if (resp_valid_o !== 1'b1 || resp_data_o !== prev_data) begin
          failures++;
          $display("FAIL valid_hold: valid=%b data=%h, expected valid=1 data=%h", resp_valid_o, resp_data_o, prev_data);
        end
      end
      if (resp_valid_o) begin
        checks++;
        if (ipulse_o !== 1'b0) begin
          failures++;
          $display("FAIL pulse_in_emit: ipulse_o=%b, expected 0", ipulse_o);
        end
      end
      if (resp_valid_o && resp_ready_i) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word: got %h, none expected", resp_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          if (resp_data_o !== exp_w) begin
            failures++;
            $display("FAIL resp_word: got %h, expected %h", resp_data_o, exp_w);
          end
        end
      end
      if (done_o) done_cnt++;
    end
    if (ichallenge_o !== prev_chal) chal_cyc = cyc;
    prev_pulse = ipulse_o;
    prev_valid = resp_valid_o;
    prev_ready = resp_ready_i;
    prev_chal  = ichallenge_o;
    prev_data  = resp_data_o;
  end

  function automatic bit cond(input int sel);
    case (sel)
      0:       cond = ipulse_o;
      1:       cond = !ipulse_o;
      2:       cond = resp_valid_o;
      default: cond = done_o;
    endcase
  endfunction

  task automatic wait_until(input int sel, input int budget, input string what, output bit ok);
    int k;
    k = 0;
    while (!cond(sel) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    ok = cond(sel);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL timeout_%s: event not seen within %0d cycles", what, budget);
    end
  endtask

  task automatic start_run(input logic [15:0] seed, input logic [15:0] count);
    seed_i  = seed;
    count_i = count;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  // mode 0: all ones, 1: alternating from 1, 2: random bits.
  task automatic do_run(input logic [15:0] seed, input int count, input int mode,
                        input int stall, input bit restart);
    int p0, d0, nb;
    logic [31:0] w, cap_d;
    logic [15:0] ec, cap_c;
    bit b, ok, boundary;
    p0 = pulse_cnt;
    d0 = done_cnt;
    ec = (seed == 16'd0) ? 16'h0001 : seed;
    w  = '0;
    nb = 0;
    resp_ready_i = (stall == 0);
    start_run(seed, 16'(count));
    for (int i = 0; i < count; i++) begin
      wait_until(0, 100, "pulse", ok);
      if (!ok) return;
      checks++;
      if (ichallenge_o !== ec) begin
        failures++;
        $display("FAIL challenge[%0d]: got %h, expected %h", i, ichallenge_o, ec);
      end
      case (mode)
        0:       b = 1'b1;
        1:       b = (i % 2 == 0);
        default: b = 1'($urandom_range(0, 1));
      endcase
      oresponse_i = b;
      w[nb] = b;
      nb++;
      if (restart && i == 0) begin
        start_run(16'h1234, 16'd40);
      end
      boundary = (nb == 32) || (i == count - 1);
      if (boundary) begin
        exp_q.push_back(w);
        w  = '0;
        nb = 0;
      end
      ec = model_next(ec);
      if (boundary && stall > 0) begin
        wait_until(2, 100, "valid", ok);
        if (!ok) return;
        cap_d = resp_data_o;
        cap_c = ichallenge_o;
        repeat (stall) begin
          @(posedge clk); #1;
          checks++;
          if (resp_valid_o !== 1'b1 || resp_data_o !== cap_d || ipulse_o !== 1'b0 || ichallenge_o !== cap_c) begin
            failures++;
            $display("FAIL stall_hold: valid=%b data=%h pulse=%b chal=%h, expected 1 %h 0 %h",
                     resp_valid_o, resp_data_o, ipulse_o, ichallenge_o, cap_d, cap_c);
          end
        end
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        checks++;
        if (resp_valid_o !== 1'b0) begin
          failures++;
          $display("FAIL valid_drop: got %b, expected 0", resp_valid_o);
        end
      end else begin
        wait_until(1, 100, "pulse_low", ok);
        if (!ok) return;
      end
    end
    wait_until(3, 400, "done", ok);
    checks++;
    if (busy_o !== 1'b0) begin
      failures++;
      $display("FAIL busy_at_done: got %b, expected 0", busy_o);
    end
    repeat (20) @(posedge clk);
    #1;
    resp_ready_i = 1'b1;
    checks++;
    if (pulse_cnt - p0 != count) begin
      failures++;
      $display("FAIL pulse_count: got %0d, expected %0d", pulse_cnt - p0, count);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL done_count: got %0d, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ichallenge_o !== 16'h0) begin failures++; $display("FAIL rst_chal: got %h, expected 0", ichallenge_o); end
    checks++;
    if (ipulse_o !== 1'b0) begin failures++; $display("FAIL rst_pulse: got %b, expected 0", ipulse_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, expected 0", busy_o); end
    checks++;
    if (done_o !== 1'b0) begin failures++; $display("FAIL rst_done: got %b, expected 0", done_o); end
    checks++;
    if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid: got %b, expected 0", resp_valid_o); end
    checks++;
    if (resp_data_o !== 32'h0) begin failures++; $display("FAIL rst_data: got %h, expected 0", resp_data_o); end
    wb_rst_i = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    do_run(16'hACE1, 2, 0, 0, 1'b0);
  endtask

  task automatic test_multiword;
    do_run(16'hBEEF, 33, 1, 0, 1'b0);
  endtask

  task automatic test_backpressure;
    do_run(16'h1D2C, 33, 2, 20, 1'b0);
  endtask

  task automatic test_seed_zero;
    do_run(16'h0000, 2, 0, 0, 1'b0);
  endtask

  task automatic test_count_zero;
    logic [15:0] c0;
    int d0;
    bit seen_busy;
    c0 = ichallenge_o;
    d0 = done_cnt;
    seen_busy = 1'b0;
    start_run(16'h7777, 16'd0);
    checks++;
    if (done_o !== 1'b1) begin failures++; $display("FAIL cnt0_done: got %b, expected 1", done_o); end
    seen_busy = busy_o;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy_o) seen_busy = 1'b1;
    end
    checks++;
    if (seen_busy !== 1'b0) begin failures++; $display("FAIL cnt0_busy: busy seen %b, expected 0", seen_busy); end
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL cnt0_done_count: got %0d, expected 1", done_cnt - d0); end
    checks++;
    if (ichallenge_o !== c0) begin failures++; $display("FAIL cnt0_chal: got %h, expected %h", ichallenge_o, c0); end
  endtask

  task automatic test_start_ignored;
    do_run(16'h3C5A, 3, 1, 0, 1'b1);
  endtask

  // Bit 0: low until 2 cycles before SAMPLE, high only in the last cycle.
  // Bit 1: high 2 cycles before SAMPLE, low in the last cycle.
  task automatic test_sync;
    bit ok;
    int d0;
    d0 = done_cnt;
    resp_ready_i = 1'b1;
    start_run(16'h00FF, 16'd2);
    for (int i = 0; i < 2; i++) begin
      wait_until(0, 100, "sync_pulse", ok);
      if (!ok) return;
      oresponse_i = 1'b0;
      if (i == 0) begin
        repeat (5) @(posedge clk);
        #1;
        oresponse_i = 1'b1;
      end else begin
        repeat (4) @(posedge clk);
        #1;
        oresponse_i = 1'b1;
        exp_q.push_back(32'h0000_0002);
        @(posedge clk); #1;
        oresponse_i = 1'b0;
      end
    end
    wait_until(3, 100, "sync_done", ok);
    @(posedge clk); #1;
    checks++;
    if (done_cnt - d0 != 1) begin failures++; $display("FAIL sync_done_count: got %0d, expected 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int d0, q0;
    q0 = exp_q.size();
    start_run(16'hABCD, 16'd5);
    wait_until(0, 100, "rst_pulse", ok);
    if (!ok) return;
    wb_rst_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ipulse_o !== 1'b0) begin failures++; $display("FAIL midrst_pulse: got %b, expected 0", ipulse_o); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b, expected 0", busy_o); end
    checks++;
    if (resp_valid_o !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b, expected 0", resp_valid_o); end
    checks++;
    if (ichallenge_o !== 16'h0) begin failures++; $display("FAIL midrst_chal: got %h, expected 0", ichallenge_o); end
    @(posedge clk); #1;
    wb_rst_i = 1'b0;
    d0 = done_cnt;
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (done_cnt != d0) begin failures++; $display("FAIL midrst_done: %0d done pulses, expected 0", done_cnt - d0); end
    checks++;
    if (busy_o !== 1'b0) begin failures++; $display("FAIL midrst_idle: busy=%b, expected 0", busy_o); end
    checks++;
    if (exp_q.size() != q0) begin failures++; $display("FAIL midrst_queue: size %0d, expected %0d", exp_q.size(), q0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multiword();
    test_backpressure();
    test_seed_zero();
    test_count_zero();
    test_start_ignored();
    test_sync();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_words: %0d expected words never emitted, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
